// File: rtl/axis_arb_pkg.sv
// Shared types and sizing helpers for the AXI-Stream UART TX arbiter and its
// round-robin picker.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  localparam int ARB_BYTE_W = 8;
  localparam int ARB_CNT_W  = 8;

  // A disabled timeout (0) still needs a 1-bit counter to keep the port widths legal.
  function automatic int arb_idle_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin priority encoder: the first request after last_ptr
// (modulo N) wins.
module rr_arb_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [2*N-1:0] req2;
  int             off;
  int             cand;

  // Rotating a doubled copy puts candidate last_ptr+1 at bit 0.
  always_comb begin
    req2    = {req, req} >> (int'(last_ptr) + 1);
    any     = 1'b0;
    off     = 0;
    for (int i = 0; i < N; i++) begin
      if (!any && req2[i]) begin
        any = 1'b1;
        off = i;
      end
    end
    cand    = (int'(last_ptr) + 1 + off) % N;
    winner  = any ? (N'(1) << cand) : '0;
    win_idx = any ? IDX_W'(cand) : '0;
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-aware round-robin arbiter that shares one AXI-Stream byte sink among
// NUM_SRC byte sources, holding the grant until tlast, MAX_BURST or idle timeout.
module axis_uart_tx_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ARB_BYTE_W*NUM_SRC-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]            i_tvalid,
  input  logic [NUM_SRC-1:0]            i_tlast,
  output logic [NUM_SRC-1:0]            i_tready,
  output logic [ARB_BYTE_W-1:0]         o_tdata,
  output logic                          o_tvalid,
  output logic                          o_tlast,
  input  logic                          o_tready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IDLE_W = arb_idle_w(IDLE_TIMEOUT);
  localparam logic [ARB_CNT_W-1:0] BURST_LIMIT = ARB_CNT_W'(MAX_BURST);
  localparam logic [IDLE_W-1:0]    IDLE_LIMIT  =
    (IDLE_TIMEOUT > 0) ? IDLE_W'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [IDLE_W-1:0]    IDLE_MAX    = '1;

  arb_state_t           state;
  logic [IDX_W-1:0]     gidx;
  logic [IDX_W-1:0]     last_ptr;
  logic [ARB_CNT_W-1:0] burst_cnt;
  logic [IDLE_W-1:0]    idle_cnt;

  logic [NUM_SRC-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 valid_g;
  logic                 last_g;
  logic                 beat;
  logic                 burst_hit;
  logic                 idle_hit;
  logic                 exit_xfer;

  rr_arb_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (i_tvalid),
    .last_ptr (last_ptr),
    .winner   (pick_onehot),
    .win_idx  (pick_idx),
    .any      (pick_any)
  );

  // grant is all zero outside XFER, so the mux naturally drives zeros when idle.
  always_comb begin
    o_tdata = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant[k]) begin
        o_tdata = i_tdata[k*ARB_BYTE_W +: ARB_BYTE_W];
      end
    end
    valid_g  = |(grant & i_tvalid);
    last_g   = |(grant & i_tlast);
    o_tvalid = valid_g;
    o_tlast  = last_g;
    i_tready = grant & {NUM_SRC{o_tready}};
  end

  assign busy      = (state == ARB_XFER);
  assign beat      = valid_g & o_tready;
  assign burst_hit = beat && ((burst_cnt + ARB_CNT_W'(1)) == BURST_LIMIT);
  assign idle_hit  = (IDLE_TIMEOUT != 0) && !valid_g && (idle_cnt == IDLE_LIMIT);
  assign exit_xfer = busy && ((beat && last_g) || burst_hit || idle_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      gidx      <= '0;
      last_ptr  <= IDX_W'(NUM_SRC - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick_any) begin
        state <= ARB_XFER;
        grant <= pick_onehot;
        gidx  <= pick_idx;
      end
    end else if (exit_xfer) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      last_ptr  <= gidx;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (beat) begin
        burst_cnt <= burst_cnt + ARB_CNT_W'(1);
      end
      if (valid_g) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Directed scoreboard bench for axis_uart_tx_arbiter with two sources,
// MAX_BURST=4 and IDLE_TIMEOUT=8.
module tb_axis_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] src;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_tdata;
  logic [1:0]  i_tvalid;
  logic [1:0]  i_tlast;
  logic [1:0]  i_tready;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        o_tlast;
  logic        o_tready;
  logic [1:0]  grant;
  logic        busy;

  logic [8:0]  srcQ0[$];
  logic [8:0]  srcQ1[$];
  beat_t       sbQ[$];

  int          nChecks    = 0;
  int          nPass      = 0;
  int          cyc        = 0;
  int          beatCount  = 0;
  int          grantCount = 0;

  axis_uart_tx_arbiter #(
    .NUM_SRC      (2),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tlast  (i_tlast),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tlast  (o_tlast),
    .o_tready (o_tready),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                  name, cyc, actual, expected);
  endtask

  task automatic applyStimulus(input int src, input logic [7:0] d, input logic last);
    if (src == 0) srcQ0.push_back({last, d});
    else          srcQ1.push_back({last, d});
  endtask

  task automatic expectBeat(input int src, input logic [7:0] d, input logic last);
    beat_t b;
    b.src  = 2'(src);
    b.last = last;
    b.data = d;
    sbQ.push_back(b);
  endtask

  task automatic driveSources();
    logic [8:0] h0;
    logic [8:0] h1;
    h0 = (srcQ0.size() > 0) ? srcQ0[0] : 9'h000;
    h1 = (srcQ1.size() > 0) ? srcQ1[0] : 9'h000;
    i_tvalid = {(srcQ1.size() > 0), (srcQ0.size() > 0)};
    i_tdata  = {h1[7:0], h0[7:0]};
    i_tlast  = {h1[8], h0[8]};
  endtask

  // Sources pop their head byte on every handshake seen before the edge.
  task automatic stepCycle();
    logic [1:0] fire;
    @(negedge clk);
    fire = i_tvalid & i_tready;
    @(posedge clk);
    #1;
    if (fire[0]) void'(srcQ0.pop_front());
    if (fire[1]) void'(srcQ1.pop_front());
    cyc++;
    driveSources();
    #1;
  endtask

  task automatic resetDut();
    rst_n    = 1'b0;
    o_tready = 1'b1;
    srcQ0.delete();
    srcQ1.delete();
    sbQ.delete();
    driveSources();
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    driveSources();
    rst_n      = 1'b1;
    cyc        = 0;
    beatCount  = 0;
    grantCount = 0;
    #1;
  endtask

  initial begin : monitor
    beat_t act;
    beat_t exp;
    logic  prevStall;
    logic  prevBusy;
    logic [7:0] prevData;
    prevStall = 1'b0;
    prevBusy  = 1'b0;
    prevData  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStall = 1'b0;
        prevBusy  = 1'b0;
      end else begin
        if (busy && !prevBusy) grantCount++;
        prevBusy = busy;
        if (prevStall && o_tvalid) checkOutput("hold_data", {24'h0, o_tdata}, {24'h0, prevData});
        prevStall = o_tvalid && !o_tready;
        prevData  = o_tdata;
        if (o_tvalid && o_tready) begin
          beatCount++;
          act.src  = (grant == 2'b01) ? 2'd0 : (grant == 2'b10) ? 2'd1 : 2'd3;
          act.last = o_tlast;
          act.data = o_tdata;
          if (sbQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected_beat (cycle %0d): got 0x%0h, expected no beat",
                     cyc, act);
          end else begin
            exp = sbQ.pop_front();
            checkOutput("beat", {21'h0, act}, {21'h0, exp});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "[TB] bench timeout");
  end

  initial begin
    rst_n    = 1'b0;
    o_tready = 1'b1;
    i_tdata  = '0;
    i_tvalid = '0;
    i_tlast  = '0;

    // Single 3-byte packet from source 0; valid is already up during reset.
    resetDut();
    applyStimulus(0, 8'h41, 1'b0); expectBeat(0, 8'h41, 1'b0);
    applyStimulus(0, 8'h42, 1'b0); expectBeat(0, 8'h42, 1'b0);
    applyStimulus(0, 8'h43, 1'b1); expectBeat(0, 8'h43, 1'b1);
    driveSources();
    #1;
    checkOutput("rst_grant",  grant,    32'h0);
    checkOutput("rst_busy",   busy,     32'h0);
    checkOutput("rst_tvalid", o_tvalid, 32'h0);
    checkOutput("rst_tdata",  o_tdata,  32'h0);
    checkOutput("rst_tlast",  o_tlast,  32'h0);
    checkOutput("rst_ready",  i_tready, 32'h0);
    releaseReset();
    checkOutput("t1_grant_c0", grant, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      checkOutput("t1_grant", grant, (c <= 3) ? 32'h1 : 32'h0);
      checkOutput("t1_ready1", i_tready[1], 32'h0);
    end
    checkOutput("t1_sb_empty", sbQ.size(), 32'h0);

    // Both sources stream 2-byte packets: strict alternation with one idle gap.
    resetDut();
    applyStimulus(0, 8'hA0, 1'b0); applyStimulus(0, 8'hA1, 1'b1);
    applyStimulus(0, 8'hA2, 1'b0); applyStimulus(0, 8'hA3, 1'b1);
    applyStimulus(1, 8'hB0, 1'b0); applyStimulus(1, 8'hB1, 1'b1);
    applyStimulus(1, 8'hB2, 1'b0); applyStimulus(1, 8'hB3, 1'b1);
    expectBeat(0, 8'hA0, 1'b0); expectBeat(0, 8'hA1, 1'b1);
    expectBeat(1, 8'hB0, 1'b0); expectBeat(1, 8'hB1, 1'b1);
    expectBeat(0, 8'hA2, 1'b0); expectBeat(0, 8'hA3, 1'b1);
    expectBeat(1, 8'hB2, 1'b0); expectBeat(1, 8'hB3, 1'b1);
    releaseReset();
    for (int c = 1; c <= 12; c++) begin
      stepCycle();
      checkOutput("t2_grant", grant,
                  (c % 3 == 0) ? 32'h0 : (((c / 3) % 2 == 0) ? 32'h1 : 32'h2));
      if (c % 3 == 0) checkOutput("t2_gap_tvalid", o_tvalid, 32'h0);
    end
    checkOutput("t2_sb_empty", sbQ.size(), 32'h0);

    // Source 1 sends 10 bytes with MAX_BURST=4: forced exits after bytes 4 and 8.
    resetDut();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 8'h60 + 8'(i), (i == 9));
      expectBeat(1, 8'h60 + 8'(i), (i == 9));
    end
    releaseReset();
    for (int c = 1; c <= 13; c++) begin
      stepCycle();
      checkOutput("t3_grant", grant, (c == 5 || c == 10 || c == 13) ? 32'h0 : 32'h2);
    end
    checkOutput("t3_grant_count", grantCount, 32'd3);
    checkOutput("t3_sb_empty", sbQ.size(), 32'h0);

    // Sink ready toggles every cycle during a 4-byte packet.
    resetDut();
    applyStimulus(0, 8'h71, 1'b0); expectBeat(0, 8'h71, 1'b0);
    applyStimulus(0, 8'h72, 1'b0); expectBeat(0, 8'h72, 1'b0);
    applyStimulus(0, 8'h73, 1'b0); expectBeat(0, 8'h73, 1'b0);
    applyStimulus(0, 8'h74, 1'b1); expectBeat(0, 8'h74, 1'b1);
    releaseReset();
    for (int c = 1; c <= 10; c++) begin
      stepCycle();
      o_tready = (c % 2 == 0);
      checkOutput("t4_grant", grant, (c <= 8) ? 32'h1 : 32'h0);
    end
    checkOutput("t4_beats", beatCount, 32'd4);
    checkOutput("t4_sb_empty", sbQ.size(), 32'h0);

    // Source 0 stalls without tlast; source 1 waits for the idle timeout.
    resetDut();
    applyStimulus(0, 8'h81, 1'b0); expectBeat(0, 8'h81, 1'b0);
    applyStimulus(1, 8'h91, 1'b1); expectBeat(1, 8'h91, 1'b1);
    releaseReset();
    for (int c = 1; c <= 12; c++) begin
      stepCycle();
      checkOutput("t5_grant", grant,
                  (c <= 9) ? 32'h1 : (c == 11) ? 32'h2 : 32'h0);
      if (c >= 2 && c <= 9) checkOutput("t5_ready1", i_tready[1], 32'h0);
    end
    checkOutput("t5_sb_empty", sbQ.size(), 32'h0);

    // Reset lands on byte 2 of a 5-byte packet.
    resetDut();
    applyStimulus(0, 8'hA1, 1'b0);
    applyStimulus(0, 8'hA2, 1'b0);
    applyStimulus(0, 8'hA3, 1'b0);
    applyStimulus(0, 8'hA4, 1'b0);
    applyStimulus(0, 8'hA5, 1'b1);
    applyStimulus(1, 8'hB1, 1'b1);
    expectBeat(0, 8'hA1, 1'b0);
    releaseReset();
    stepCycle();
    checkOutput("t6_grant_c1", grant, 32'h1);
    stepCycle();
    checkOutput("t6_tvalid_pre", o_tvalid, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_tvalid", o_tvalid, 32'h0);
    checkOutput("t6_async_ready",  i_tready, 32'h0);
    checkOutput("t6_async_grant",  grant,    32'h0);
    checkOutput("t6_async_busy",   busy,     32'h0);
    checkOutput("t6_sb_empty_pre", sbQ.size(), 32'h0);
    srcQ0.delete();
    applyStimulus(0, 8'hC1, 1'b1);
    expectBeat(0, 8'hC1, 1'b1);
    expectBeat(1, 8'hB1, 1'b1);
    driveSources();
    @(posedge clk);
    #1;
    releaseReset();
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      checkOutput("t6_grant_after", grant,
                  (c == 1) ? 32'h1 : (c == 3) ? 32'h2 : 32'h0);
    end
    checkOutput("t6_sb_empty", sbQ.size(), 32'h0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
